// File: rtl/pc_pkg.sv
// Shared types and command decode for the pc_stack program counter.
// Used by pc_stack and pc_ret_stack via import pc_pkg::*.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Call on a full stack degrades to a plain load; ret on empty holds.
    function automatic pc_op_e pc_decode(
        input logic load,
        input logic call,
        input logic ret,
        input logic inc,
        input logic full,
        input logic empty
    );
        pc_op_e op;
        if (load)      op = PC_LOAD;
        else if (call) op = full  ? PC_LOAD : PC_CALL;
        else if (ret)  op = empty ? PC_HOLD : PC_RET;
        else if (inc)  op = PC_INC;
        else           op = PC_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address storage with level counter for pc_stack.
// Push when full and pop when empty are ignored.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q, level_d;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_idx = IW'(level_q);
    assign rd_idx = IW'(level_q - 1'b1);
    assign top_o  = empty_o ? '0 : mem_q[rd_idx];

    always_comb begin
        level_d = level_q;
        if (do_push)     level_d = level_q + 1'b1;
        else if (do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) level_q <= '0;
        else          level_q <= level_d;
    end

    // Storage needs no reset: entries above level are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IW'(i)) mem_q[i] <= data_i;
            end
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack (call/ret), sticky errors.
// Define PC_STACK_ERR_EN to enable overflow/underflow flags and err_clr.
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pc_inc, top;
    logic             push, pop;
    pc_op_e           op;

    assign pc_inc = out_q + WIDTH'(1);
    assign op     = pc_decode(load, call, ret, inc, full, empty);
    assign out    = out_q;

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (top),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        out_d = out_q;
        push  = 1'b0;
        pop   = 1'b0;
        unique case (op)
            PC_LOAD: out_d = in;
            PC_CALL: begin
                out_d = in;
                push  = 1'b1;
            end
            PC_RET: begin
                out_d = top;
                pop   = 1'b1;
            end
            PC_INC:  out_d = pc_inc;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) out_q <= '0;
        else          out_q <= out_d;
    end

`ifdef PC_STACK_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic ovf_ev, unf_ev;

    assign ovf_ev = !load && call && full;
    assign unf_ev = !load && !call && ret && empty;

    // A fresh error in the clearing cycle keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_ev) ovf_d = 1'b1;
        if (unf_ev) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: queue-based reference model, directed
// sequences then randomized commands; monitor checks every cycle.
module tb_pc_stack;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        logic [W-1:0]  pc;
        logic [LW-1:0] lvl;
        logic          f;
        logic          e;
        logic          o;
        logic          u;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  in = '0;
    logic          load = 1'b0;
    logic          inc = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  out;
    logic [LW-1:0] level;
    logic          full, empty, overflow, underflow;

    int   checks = 0;
    int   passes = 0;
    exp_t expq[$];

    int   m_pc;
    int   m_stk[$];
    bit   m_ov, m_un;

    pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .err_clr   (err_clr),
        .out       (out),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT state shortly after each active edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (out !== e.pc || level !== e.lvl || full !== e.f ||
                empty !== e.e || overflow !== e.o || underflow !== e.u)
                $display("FAIL state t=%0t got out=%h lvl=%0d f=%b e=%b o=%b u=%b want out=%h lvl=%0d f=%b e=%b o=%b u=%b",
                         $time, out, level, full, empty, overflow, underflow,
                         e.pc, e.lvl, e.f, e.e, e.o, e.u);
            else
                passes++;
        end
    end

    task automatic step(input bit rn, input bit ld, input bit cl,
                        input bit rt, input bit ic, input bit ec,
                        input int d);
        exp_t e;
        bit oe, ue;
        @(negedge clk);
        reset_n = rn; load = ld; call = cl; ret = rt;
        inc = ic; err_clr = ec; in = W'(d);
        oe = 0;
        ue = 0;
        if (!rn) begin
            m_pc = 0;
            m_stk.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            if (ld) m_pc = d & MASK;
            else if (cl) begin
                if (m_stk.size() < D) m_stk.push_back((m_pc + 1) & MASK);
                else oe = 1;
                m_pc = d & MASK;
            end else if (rt) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else ue = 1;
            end else if (ic) m_pc = (m_pc + 1) & MASK;
`ifdef PC_STACK_ERR_EN
            m_ov = (m_ov && !ec) || oe;
            m_un = (m_un && !ec) || ue;
`else
            m_ov = 0;
            m_un = 0;
`endif
        end
        e.pc  = W'(m_pc);
        e.lvl = LW'(m_stk.size());
        e.f   = (m_stk.size() == D);
        e.e   = (m_stk.size() == 0);
        e.o   = m_ov;
        e.u   = m_un;
        expq.push_back(e);
    endtask

    task automatic do_inc(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0);
        do_inc(5);
        step(0, 0, 0, 0, 1, 0, 0);
        do_inc(3);
        step(0, 0, 0, 0, 0, 0, 0);
        // counter wrap
        step(1, 1, 0, 0, 0, 0, 'hFFFE);
        do_inc(3);
        // call / ret round trip
        step(1, 1, 0, 0, 0, 0, 'h10);
        step(1, 0, 1, 0, 0, 0, 'h40);
        do_inc(2);
        step(1, 0, 0, 1, 0, 0, 0);
        // fill and overflow, then drain in LIFO order and underflow
        for (int i = 1; i <= D + 1; i++) step(1, 0, 1, 0, 0, 0, i * 'h100);
        for (int i = 0; i <= D + 1; i++) step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // priority cases
        step(1, 1, 1, 1, 1, 0, 'h55);
        step(1, 0, 1, 1, 1, 0, 'h77);
        step(1, 0, 0, 1, 1, 0, 0);
        // back-to-back call/ret
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 0, 0, 'h1000 + i);
            step(1, 0, 0, 1, 0, 0, 0);
        end
        // reset mid-sequence with entries stacked
        step(1, 0, 1, 0, 0, 0, 'h300);
        step(1, 0, 1, 0, 0, 0, 'h400);
        step(0, 0, 1, 0, 0, 0, 'h500);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 63) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MASK)));
        @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0)
            $display("FAIL drain got pending=%0d want 0", expq.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised successor to the Hack program counter. It adds a configurable width, an explicit increment enable, and an on-chip return-address stack. Call pushes the return address and jumps; return pops the saved address back into the counter. It sits in the CPU between the control decoder and instruction-memory address bus, replacing the fixed 16-bit counter.

## Interface
Parameters:
- WIDTH, 16, counter/address width in bits (≥2)
- DEPTH, 8, return-stack entries (≥1)

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge
- reset_n  input  1  synchronous, active-low reset (sampled on clk; no asynchronous path)
- in  input  WIDTH  jump/call target
- load  input  1  load in into out
- inc  input  1  increment out
- call  input  1  push out+1, then load in
- ret  input  1  pop stack top into out
- err_clr  input  1  clear sticky error flags
- out  output  WIDTH  current program counter (registered)
- level  output  $clog2(DEPTH+1)  number of valid stack entries
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- overflow  output  1  sticky: call attempted while full
- underflow  output  1  sticky: ret attempted while empty

## Operation
- Command priority per cycle is reset, then load, call, ret, inc, and finally hold. Exactly one action is taken; lower-priority requests in the same cycle are ignored.
- reset_n=0: out←0, level←0, overflow←0, underflow←0. Stack storage contents are don't-care.
- load: out←in. Stack unchanged.
- call, not full: stack[level]←out+1 (mod 2^WIDTH), level←level+1, out←in.
- call, full: out←in, stack and level unchanged, overflow←1.
- ret, not empty: out←stack[level−1], level←level−1.
- ret, empty: out unchanged, underflow←1.
- inc: out←out+1 (mod 2^WIDTH). 2^WIDTH−1 wraps to 0.
- hold: all state unchanged.
- err_clr: clears overflow and underflow in the same edge. A new error event in that cycle wins, so the flag stays 1.
- full, empty and level are derived combinationally from the level register.

## Timing
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.
- Latency: every command is visible on out one cycle after the sampling edge.
- Back-to-back call/ret in consecutive cycles is fully supported. A ret in cycle N+1 returns the address pushed in cycle N.
- Reset mid-sequence discards all stacked addresses. The first post-reset out is 0.
- No handshake; commands are single-cycle pulses or levels and are re-evaluated every edge.

## Configuration
- PC_STACK_ERR_EN defined: overflow and underflow behave as above, and err_clr is functional.
- PC_STACK_ERR_EN undefined: overflow and underflow are tied to 0, and err_clr is ignored. Full and empty call/ret behaviour is otherwise identical: call on full drops the push, ret on empty holds.

## Structure
- Shared package pc_pkg holds:
  - enum pc_op_e {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET}
  - function pc_decode(load, call, ret, inc, full, empty) that returns the winning op
- Sub-module pc_ret_stack holds the LIFO storage and level counter:
  - Inputs: push, pop, push data.
  - Outputs: top, level, full, empty.
  - Storage is a DEPTH×WIDTH register array.
- The top level holds the out register, the decode, and the error flags.

## Test plan
- Reset, then inc held for 5 cycles → out 0,1,2,3,4,5. With reset_n=0 asserted at out=3 → out=0 and level=0 on the next edge.
- WIDTH=4: load 4'hE, then inc ×3 → out 14, 15, 0, 1 (wrap).
- At out=0x10, call in=0x40 → out=0x40, level=1. Then inc ×2, then ret → out=0x11, level=0.
- DEPTH=2: call ×3 with targets 0x100, 0x200, 0x300 → out=0x300, level=2, overflow=1. Then ret ×2 returns the first two pushed return addresses in LIFO order.
- Empty stack: ret → out unchanged, underflow=1. err_clr → underflow=0. In a build without PC_STACK_ERR_EN, underflow stays 0.
- Same-cycle load=1, call=1, ret=1, in=0x55 → out=0x55, level unchanged. Same-cycle call=1, ret=1 → push occurs, ret ignored.
